othello_task_dispatcher: RTL and testbench

Initiator side of the endgame solver interface. It takes board positions (player/opponent bitboards plus a tag) from the host over a valid/ready stream and buffers them in a small FIFO. It issues them one at a time to the `pipeline` solver core by driving the board and enable, then waits for `solved` and returns the signed disc-difference result with tag, cycle count and timeout flag on a valid/ready result stream.

---
 rtl/othello_task_dispatcher.sv | 197 +++++++++++++++++++
 tb/tb_othello_task_dispatcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/othello_task_dispatcher.sv
// Othello endgame task dispatcher: buffers host board positions in a FIFO,
// runs them one at a time on the solver core and returns scored results.
module othello_task_dispatcher #(
  parameter int unsigned TAG_W        = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SETUP_CYCLES = 5,
  parameter logic [31:0] TIMEOUT      = 32'd10000000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iTaskValid,
  output logic             oTaskReady,
  input  logic [63:0]      iTaskPlayer,
  input  logic [63:0]      iTaskOpponent,
  input  logic [TAG_W-1:0] iTaskTag,
  output logic [63:0]      oPlayer,
  output logic [63:0]      oOpponent,
  output logic             oEnable,
  input  logic             iSolved,
  input  logic [7:0]       iRes,
  output logic             oResValid,
  input  logic             iResReady,
  output logic [7:0]       oResScore,
  output logic [TAG_W-1:0] oResTag,
  output logic [CNT_W-1:0] oResCycles,
  output logic             oResTimeout,
  output logic             oBusy
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  typedef struct packed {
    logic [63:0]      player;
    logic [63:0]      opponent;
    logic [TAG_W-1:0] tag;
  } task_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;

  task_t              mem [FIFO_DEPTH];
  task_t              task_in;
  task_t              head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FCNT_W-1:0]  count;
  logic               full;
  logic               empty;
  logic               push;

  logic [SETUP_W-1:0] setup_cnt;
  logic [CNT_W-1:0]   run_cnt;
  logic [CNT_W-1:0]   run_inc;
  logic [TAG_W-1:0]   tag_q;
  logic               setup_last;
  logic               timeout_hit;

  logic               pop_c;
  logic               solve_c;
  logic               abort_c;
  logic               enable_d_c;
  logic               res_valid_d_c;

  assign task_in     = '{player: iTaskPlayer, opponent: iTaskOpponent, tag: iTaskTag};
  assign head        = mem[rd_ptr];
  assign full        = (count == FCNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign oTaskReady  = !full && !iRESET;
  assign push        = iTaskValid && oTaskReady;
  assign oBusy       = (state != S_IDLE) || !empty;

  assign run_inc     = run_cnt + CNT_W'(1);
  assign timeout_hit = (run_inc == CNT_W'(TIMEOUT));
  assign setup_last  = (setup_cnt == SETUP_W'(SETUP_CYCLES - 1));

  // Task storage; contents need no reset since count gates every read.
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      mem[wr_ptr] <= task_in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop_c})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a solve beats a timeout in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (!empty)                 state_next = S_LOAD;
      S_LOAD: if (setup_last)             state_next = S_RUN;
      S_RUN:  if (iSolved || timeout_hit) state_next = S_DONE;
      S_DONE: if (iResReady)              state_next = S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
  end

  // FSM output decode feeding the registered datapath.
  always_comb begin
    pop_c         = 1'b0;
    solve_c       = 1'b0;
    abort_c       = 1'b0;
    enable_d_c    = (state_next == S_RUN);
    res_valid_d_c = (state_next == S_DONE);
    case (state)
      S_IDLE:  pop_c   = !empty;
      S_RUN: begin
        solve_c = iSolved;
        abort_c = !iSolved && timeout_hit;
      end
      default: ;
    endcase
  end

  // Solver-side board, counters and result registers.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      oPlayer     <= '0;
      oOpponent   <= '0;
      oEnable     <= 1'b0;
      oResValid   <= 1'b0;
      oResScore   <= '0;
      oResTag     <= '0;
      oResCycles  <= '0;
      oResTimeout <= 1'b0;
      tag_q       <= '0;
      setup_cnt   <= '0;
      run_cnt     <= '0;
    end else begin
      oEnable   <= enable_d_c;
      oResValid <= res_valid_d_c;
      if (pop_c) begin
        oPlayer   <= head.player;
        oOpponent <= head.opponent;
        tag_q     <= head.tag;
        setup_cnt <= '0;
        run_cnt   <= '0;
      end else begin
        if (state == S_LOAD) begin
          setup_cnt <= setup_cnt + SETUP_W'(1);
        end
        if (state == S_RUN) begin
          run_cnt <= run_inc;
        end
      end
      if (solve_c) begin
        oResScore   <= iRes;
        oResTag     <= tag_q;
        oResCycles  <= run_inc;
        oResTimeout <= 1'b0;
      end else if (abort_c) begin
        oResScore   <= '0;
        oResTag     <= tag_q;
        oResCycles  <= CNT_W'(TIMEOUT);
        oResTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_othello_task_dispatcher.sv
// Bench for othello_task_dispatcher: behavioural solver model plus an
// in-order result scoreboard computed from each task's solve latency.
module tb_othello_task_dispatcher;

  localparam int unsigned TAG_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SETUP = 5;
  localparam int unsigned CNT_W = 32;
  // Long enough for the 200-cycle solve, short enough to exercise aborts.
  localparam int unsigned TO    = 250;
  localparam int unsigned NEVER = 0;

  logic             clk;
  logic             iRESET;
  logic             iTaskValid;
  logic             oTaskReady;
  logic [63:0]      iTaskPlayer;
  logic [63:0]      iTaskOpponent;
  logic [TAG_W-1:0] iTaskTag;
  logic [63:0]      oPlayer;
  logic [63:0]      oOpponent;
  logic             oEnable;
  logic             iSolved;
  logic [7:0]       iRes;
  logic             oResValid;
  logic             iResReady;
  logic [7:0]       oResScore;
  logic [TAG_W-1:0] oResTag;
  logic [CNT_W-1:0] oResCycles;
  logic             oResTimeout;
  logic             oBusy;

  othello_task_dispatcher #(
    .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP),
    .TIMEOUT(32'(TO)), .CNT_W(CNT_W)
  ) dut (
    .iCLOCK(clk), .iRESET(iRESET),
    .iTaskValid(iTaskValid), .oTaskReady(oTaskReady),
    .iTaskPlayer(iTaskPlayer), .iTaskOpponent(iTaskOpponent), .iTaskTag(iTaskTag),
    .oPlayer(oPlayer), .oOpponent(oOpponent), .oEnable(oEnable),
    .iSolved(iSolved), .iRes(iRes),
    .oResValid(oResValid), .iResReady(iResReady),
    .oResScore(oResScore), .oResTag(oResTag), .oResCycles(oResCycles),
    .oResTimeout(oResTimeout), .oBusy(oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] p;
    logic [63:0] o;
    logic [7:0]  tag;
    int unsigned lat;
    logic [7:0]  res;
  } tsk_t;

  tsk_t        pend[$];
  tsk_t        exp_q[$];
  int unsigned lat_of [logic [63:0]];
  logic [7:0]  res_of [logic [63:0]];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;
  int          run_cnt = 0;
  int          fall_cyc = 0;
  int          acc_cyc = 0;
  bit          en_prev = 1'b0;
  bit          probe = 1'b0;
  bit          spur = 1'b0;
  bit          rand_ready = 1'b0;
  bit          rand_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: a task solved within the timeout reports its own latency and score,
  // otherwise it is aborted at exactly TO cycles with score 0.
  function automatic bit exp_timeout(input tsk_t t);
    return (t.lat == NEVER) || (t.lat > TO);
  endfunction

  function automatic logic [63:0] exp_cycles(input tsk_t t);
    return exp_timeout(t) ? 64'(TO) : 64'(t.lat);
  endfunction

  function automatic logic [7:0] exp_score(input tsk_t t);
    return exp_timeout(t) ? 8'h00 : t.res;
  endfunction

  task automatic add_task(input logic [63:0] p, input logic [63:0] o, input logic [7:0] tag,
                          input int unsigned lat, input logic [7:0] res);
    tsk_t t;
    t.p = p; t.o = o; t.tag = tag; t.lat = lat; t.res = res;
    pend.push_back(t);
    lat_of[p] = lat;
    res_of[p] = res;
  endtask

  // One clock: sample handshakes, advance, score results, then drive the next inputs.
  task automatic cycle();
    bit           ft;
    bit           fr;
    logic [7:0]   sc;
    logic [7:0]   tg;
    logic [31:0]  cy;
    logic         to;
    tsk_t         t;
    int unsigned  lat;
    ft = iTaskValid && oTaskReady;
    fr = oResValid && iResReady && !iRESET;
    sc = oResScore; tg = oResTag; cy = oResCycles; to = oResTimeout;
    @(posedge clk);
    #1;
    cyc++;
    if (ft) begin
      t = pend.pop_front();
      exp_q.push_back(t);
      acc_cyc = cyc;
    end
    if (fr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(tg), 64'hDEAD);
      end else begin
        t = exp_q.pop_front();
        check("res_tag", 64'(tg), 64'(t.tag));
        check("res_score", 64'(sc), 64'(exp_score(t)));
        check("res_cycles", 64'(cy), exp_cycles(t));
        check("res_timeout", 64'(to), 64'(exp_timeout(t)));
      end
    end
    if (oEnable && !en_prev) begin
      if (exp_q.size() > 0) begin
        check("board_player", oPlayer, exp_q[0].p);
        check("board_opponent", oOpponent, exp_q[0].o);
      end else begin
        check("enable_without_task", 64'(oEnable), 64'(0));
      end
      check("enable_low_gap", 64'((cyc - fall_cyc) >= int'(SETUP + 1)), 64'(1));
      if (probe) begin
        check("accept_to_enable_edges", 64'(cyc - acc_cyc + 1), 64'(SETUP + 2));
        probe = 1'b0;
      end
    end
    if (!oEnable && en_prev) fall_cyc = cyc;
    en_prev = oEnable;
    // Solver model: raises solved once the board has seen lat enable cycles.
    if (oEnable) run_cnt++; else run_cnt = 0;
    lat = lat_of.exists(oPlayer) ? lat_of[oPlayer] : NEVER;
    iSolved = (oEnable && lat != NEVER && run_cnt >= int'(lat)) || (!oEnable && spur);
    iRes    = (oEnable && res_of.exists(oPlayer)) ? res_of[oPlayer] : 8'($urandom);
    if (rand_ready) iResReady = ($urandom_range(0, 3) != 0);
    if (pend.size() > 0 && (!rand_valid || $urandom_range(0, 2) != 0)) begin
      iTaskValid    = 1'b1;
      iTaskPlayer   = pend[0].p;
      iTaskOpponent = pend[0].o;
      iTaskTag      = pend[0].tag;
    end else begin
      iTaskValid    = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((pend.size() != 0 || exp_q.size() != 0 || oBusy) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) check("drain_budget_expired", 64'(k), 64'(0));
  endtask

  initial begin
    iRESET = 1'b1; iTaskValid = 1'b0; iTaskPlayer = '0; iTaskOpponent = '0;
    iTaskTag = '0; iSolved = 1'b0; iRes = '0; iResReady = 1'b1;
    #1;
    check("ready_in_reset", 64'(oTaskReady), 64'(0));
    cycle();
    cycle();
    check("rst_enable", 64'(oEnable), 64'(0));
    check("rst_res_valid", 64'(oResValid), 64'(0));
    check("rst_busy", 64'(oBusy), 64'(0));
    check("rst_player", oPlayer, 64'(0));
    check("rst_opponent", oOpponent, 64'(0));
    check("rst_score", 64'(oResScore), 64'(0));
    check("rst_tag", 64'(oResTag), 64'(0));
    check("rst_cycles", 64'(oResCycles), 64'(0));
    check("rst_timeout", 64'(oResTimeout), 64'(0));
    iRESET = 1'b0;
    #1;
    check("ready_after_reset", 64'(oTaskReady), 64'(1));
    fall_cyc = cyc;

    // Single task with enable-latency probe, then a negative score.
    probe = 1'b1;
    add_task(64'h10B8DDE3B1B98284, 64'h8E45221C4E467C78, 8'h01, 200, 8'd16);
    drain(400);
    check("latency_probe_seen", 64'(probe), 64'(0));
    add_task(64'hBF8387EBB3F8C002, 64'h407C78144C073F3D, 8'h02, 37, 8'hFE);
    drain(200);

    // Back-pressure: five tasks with results held off.
    iResReady = 1'b0;
    for (int i = 1; i <= 5; i++)
      add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'(i), 20 + i, 8'(i * 3));
    begin
      int k;
      k = 0;
      while (!oResValid && k < 300) begin cycle(); k++; end
      check("fill_result_wait", 64'(oResValid), 64'(1));
      for (int j = 0; j < 4; j++) cycle();
      check("fill_all_accepted", 64'(exp_q.size()), 64'(5));
      check("fill_ready_low", 64'(oTaskReady), 64'(0));
      check("fill_enable_low", 64'(oEnable), 64'(0));
      check("fill_busy", 64'(oBusy), 64'(1));
      check("fill_head_tag", 64'(oResTag), 64'(1));
    end
    iResReady = 1'b1;
    drain(600);

    // Timeouts and the timeout boundary, followed by normal tasks.
    add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'h10, NEVER, 8'h05);
    add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'h11, 30, 8'h07);
    add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'h12, TO, 8'hF0);
    add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'h13, TO + 1, 8'h22);
    add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'h14, 1, 8'h40);
    drain(1500);

    // Solved asserted whenever enable is low must be ignored.
    spur = 1'b1;
    add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'h30, 50, 8'hC0);
    add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'h31, 2, 8'h3F);
    drain(300);
    spur = 1'b0;

    // Randomized traffic with random valid gaps and result back-pressure.
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    for (int i = 0; i < 30; i++)
      add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'(8'h40 + i),
               $urandom_range(1, 300), 8'($urandom_range(0, 128) - 64));
    drain(12000);
    rand_ready = 1'b0;
    rand_valid = 1'b0;
    iResReady  = 1'b1;

    // Reset while running with two tasks buffered: nothing may come out.
    for (int i = 0; i < 3; i++)
      add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'(8'hA0 + i), 100, 8'h11);
    begin
      int k;
      k = 0;
      while (!(oEnable && exp_q.size() == 3) && k < 200) begin cycle(); k++; end
      check("reset_setup_reached", 64'(oEnable && exp_q.size() == 3), 64'(1));
    end
    iRESET = 1'b1;
    pend.delete();
    iTaskValid = 1'b0;
    cycle();
    exp_q.delete();
    iRESET = 1'b0;
    #1;
    check("midrst_enable", 64'(oEnable), 64'(0));
    check("midrst_res_valid", 64'(oResValid), 64'(0));
    check("midrst_ready", 64'(oTaskReady), 64'(1));
    check("midrst_busy", 64'(oBusy), 64'(0));
    for (int j = 0; j < 150; j++) cycle();
    check("midrst_stays_idle", 64'(oBusy), 64'(0));
    add_task({$urandom, $urandom}, {$urandom, $urandom}, 8'hB0, 12, 8'h09);
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
